// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle add/sub/logic/shift ops, plus MUL (shift-add) and DIV (restoring) at one bit per cycle.
// Ports: clk/rst (sync, active-high); start/alu_sel/a/b request an op; ready/done/result/result_hi/flags report it.
// done pulses 1 cycle after the accepting edge + 1 (WIDTH+1 for MUL/DIV); start is ignored while ready=0.
module iter_alu #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [7:0]       flags
);
  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = SH_W + 1;

  localparam logic [SEL_W-1:0] OP_ADD = SEL_W'(0);
  localparam logic [SEL_W-1:0] OP_SUB = SEL_W'(1);
  localparam logic [SEL_W-1:0] OP_AND = SEL_W'(2);
  localparam logic [SEL_W-1:0] OP_OR  = SEL_W'(3);
  localparam logic [SEL_W-1:0] OP_XOR = SEL_W'(4);
  localparam logic [SEL_W-1:0] OP_NOT = SEL_W'(5);
  localparam logic [SEL_W-1:0] OP_SHL = SEL_W'(6);
  localparam logic [SEL_W-1:0] OP_SHR = SEL_W'(7);
  localparam logic [SEL_W-1:0] OP_SAR = SEL_W'(8);
  localparam logic [SEL_W-1:0] OP_MUL = SEL_W'(9);
  localparam logic [SEL_W-1:0] OP_DIV = SEL_W'(10);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  // Shared MUL/DIV work register: {hi, lo} = {partial product, multiplier}
  // for MUL and {remainder, dividend/quotient} for DIV.
  logic [2*WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic [7:0]         flags_q, flags_d;

  // Result/flag evaluation from the latched operands (used in S_DONE).
  logic [SH_W-1:0]  sh;
  logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w, sar_w;
  logic [WIDTH-1:0] res_c, hi_c;
  logic             c_c, v_c, dz_c, ill_c;

  always_comb begin
    sh    = b_q[SH_W-1:0];
    add_w = {1'b0, a_q} + {1'b0, b_q};
    // Top bit of the extended difference is the borrow (a < b).
    sub_w = {1'b0, a_q} - {1'b0, b_q};
    // Extra bit on the shifted-out side captures the last bit shifted out
    // (stays 0 when sh == 0).
    shl_w = {1'b0, a_q} << sh;
    shr_w = {a_q, 1'b0} >> sh;
    sar_w = $signed({a_q, 1'b0}) >>> sh;
    res_c = '0;
    hi_c  = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    dz_c  = 1'b0;
    ill_c = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_c = add_w[WIDTH-1:0];
        c_c   = add_w[WIDTH];
        v_c   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = sub_w[WIDTH-1:0];
        c_c   = sub_w[WIDTH];
        v_c   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sub_w[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: res_c = a_q & b_q;
      OP_OR:  res_c = a_q | b_q;
      OP_XOR: res_c = a_q ^ b_q;
      OP_NOT: res_c = ~a_q;
      OP_SHL: begin
        res_c = shl_w[WIDTH-1:0];
        c_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        res_c = shr_w[WIDTH:1];
        c_c   = shr_w[0];
      end
      OP_SAR: begin
        res_c = sar_w[WIDTH:1];
        c_c   = sar_w[0];
      end
      OP_MUL: begin
        res_c = work_q[WIDTH-1:0];
        hi_c  = work_q[2*WIDTH-1:WIDTH];
        c_c   = |work_q[2*WIDTH-1:WIDTH];
        v_c   = |work_q[2*WIDTH-1:WIDTH];
      end
      OP_DIV: begin
        if (b_q == '0) begin
          res_c = '1;
          hi_c  = a_q;
          dz_c  = 1'b1;
        end else begin
          res_c = work_q[WIDTH-1:0];
          hi_c  = work_q[2*WIDTH-1:WIDTH];
        end
      end
      default: ill_c = 1'b1;
    endcase
  end

  // One iteration step for each multi-cycle op.
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_next, div_next;

  always_comb begin
    mul_sum   = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, a_q} : '0);
    mul_next  = {mul_sum, work_q[WIDTH-1:1]};
    div_trial = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    div_ge    = div_trial >= {1'b0, b_q};
    // When div_ge the true difference is < b, so WIDTH bits suffice.
    div_diff  = div_trial[WIDTH-1:0] - b_q;
    div_next  = {(div_ge ? div_diff : div_trial[WIDTH-1:0]), work_q[WIDTH-2:0], div_ge};
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = alu_sel;
          a_d    = a;
          b_d    = b;
          cnt_d  = '0;
          work_d = {{WIDTH{1'b0}}, ((alu_sel == OP_DIV) ? a : b)};
          if ((alu_sel == OP_MUL) || ((alu_sel == OP_DIV) && (b != '0)))
            state_d = S_ITER;
          else
            state_d = S_DONE;
        end
      end
      S_ITER: begin
        work_d = (op_q == OP_MUL) ? mul_next : div_next;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d     = S_IDLE;
        done_d      = 1'b1;
        result_d    = res_c;
        result_hi_d = hi_c;
        flags_d     = {2'b00, ill_c, dz_c, v_c, res_c[WIDTH-1], c_c, (res_c == '0)};
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_iter_alu.sv
// Testbench for iter_alu: directed vectors, a cycle-level behavioural model
// checked every cycle, and hand-computed literal expectations.
module tb_iter_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [7:0]   alu_sel = 8'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, done;
  logic [W-1:0] result, result_hi;
  logic [7:0]   flags;

  iter_alu #(.WIDTH(W), .SEL_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .alu_sel(alu_sel), .a(a), .b(b),
    .ready(ready), .done(done), .result(result), .result_hi(result_hi), .flags(flags)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of one operation, from the opcode table.
  task automatic model_op(input logic [7:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                          output logic [W-1:0] r, output logic [W-1:0] h,
                          output logic [7:0] f, output int lat);
    logic [63:0] p;
    logic c, v, dz, il;
    int sh;
    r = '0; h = '0; c = 0; v = 0; dz = 0; il = 0; lat = 1;
    sh = int'(y[4:0]);
    case (op)
      8'd0: begin p = 64'(x) + 64'(y); r = p[31:0]; c = p[32]; v = (x[31] == y[31]) && (r[31] != x[31]); end
      8'd1: begin r = x - y; c = (x < y); v = (x[31] != y[31]) && (r[31] != x[31]); end
      8'd2: r = x & y;
      8'd3: r = x | y;
      8'd4: r = x ^ y;
      8'd5: r = ~x;
      8'd6: begin r = x << sh; c = (sh != 0) ? x[32-sh] : 1'b0; end
      8'd7: begin r = x >> sh; c = (sh != 0) ? x[sh-1] : 1'b0; end
      8'd8: begin r = $signed(x) >>> sh; c = (sh != 0) ? x[sh-1] : 1'b0; end
      8'd9: begin p = 64'(x) * 64'(y); r = p[31:0]; h = p[63:32]; c = (h != 0); v = c; lat = W + 1; end
      8'd10: begin
        if (y == 0) begin r = '1; h = x; dz = 1; end
        else begin r = x / y; h = x % y; lat = W + 1; end
      end
      default: il = 1;
    endcase
    f = {2'b00, il, dz, v, r[31], c, (r == 0)};
  endtask

  // Cycle model: expected outputs after each rising edge.
  logic         m_busy = 0;
  int           m_left = 0;
  logic [W-1:0] m_res, m_hi;
  logic [7:0]   m_flg;
  int           m_lat;
  logic         e_ready = 1, e_done = 0;
  logic [W-1:0] e_res = '0, e_hi = '0;
  logic [7:0]   e_flg = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_left = 0;
      e_ready = 1; e_done = 0; e_res = '0; e_hi = '0; e_flg = '0;
    end else begin
      e_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; e_done = 1;
          e_res = m_res; e_hi = m_hi; e_flg = m_flg;
        end
      end else if (start) begin
        model_op(alu_sel, a, b, m_res, m_hi, m_flg, m_lat);
        m_busy = 1; m_left = m_lat;
      end
      e_ready = !m_busy;
    end
  end

  logic checking = 0;
  always @(negedge clk) begin
    if (checking) begin
      chk("ready", 64'(ready), 64'(e_ready));
      chk("done", 64'(done), 64'(e_done));
      chk("result", 64'(result), 64'(e_res));
      chk("result_hi", 64'(result_hi), 64'(e_hi));
      chk("flags", 64'(flags), 64'(e_flg));
    end
  end

  // Drive one request; returns at the negedge after the accepting edge with
  // the operands scrambled so that latching is exercised.
  task automatic start_op(input logic [7:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    alu_sel = op; a = x; b = y; start = 1;
    @(negedge clk);
    start = 0; alu_sel = 8'($urandom); a = $urandom; b = $urandom;
  endtask

  // Counts edges until done; optional start pulses while busy (incl. DONE cycle).
  task automatic wait_done(input bit pulse, output int k);
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
      if (pulse && (k == 3 || k == 10 || k == 32)) begin start = 1; alu_sel = 8'd0; end
      else start = 0;
    end
  endtask

  task automatic lit(input string nm, input int k, input int lat_x,
                     input logic [W-1:0] r, input logic [W-1:0] h, input logic [7:0] f);
    chk({nm, "_lat"}, 64'(k), 64'(lat_x));
    chk({nm, "_res"}, 64'(result), 64'(r));
    chk({nm, "_hi"}, 64'(result_hi), 64'(h));
    chk({nm, "_flags"}, 64'(flags), 64'(f));
  endtask

  typedef struct { logic [7:0] op; logic [W-1:0] x; logic [W-1:0] y; } vec_t;
  vec_t vecs[14];

  initial begin
    int k, seen, lat_m;
    logic [W-1:0] r_m, h_m;
    logic [7:0] f_m;
    vecs[0]  = '{8'd2,  32'hF0F0_1234, 32'h0FF0_FFFF};
    vecs[1]  = '{8'd3,  32'h0000_0000, 32'h0000_0000};
    vecs[2]  = '{8'd4,  32'hA5A5_A5A5, 32'hFFFF_0000};
    vecs[3]  = '{8'd5,  32'h8000_0000, 32'h0};
    vecs[4]  = '{8'd6,  32'h8000_0001, 32'd0};
    vecs[5]  = '{8'd6,  32'h0000_0003, 32'd31};
    vecs[6]  = '{8'd7,  32'h0000_0003, 32'h0000_0021};
    vecs[7]  = '{8'd1,  32'd1,         32'd2};
    vecs[8]  = '{8'd0,  32'h7FFF_FFFF, 32'd1};
    vecs[9]  = '{8'd9,  32'd0,         32'hDEAD_BEEF};
    vecs[10] = '{8'd10, 32'd5,         32'd7};
    vecs[11] = '{8'd11, 32'd1,         32'd1};
    vecs[12] = '{8'd255, 32'd0,        32'd0};
    vecs[13] = '{8'd10, 32'hFFFF_FFFF, 32'd1};

    repeat (2) @(negedge clk);
    rst = 0;
    checking = 1;
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_outputs", {done, result, result_hi, flags}, 64'd0);

    start_op(8'd0, 32'hFFFF_FFFF, 32'd1);   wait_done(0, k);
    lit("add_wrap", k, 1, 32'h0, 32'h0, 8'h03);
    start_op(8'd1, 32'h8000_0000, 32'd1);   wait_done(0, k);
    lit("sub_ovf", k, 1, 32'h7FFF_FFFF, 32'h0, 8'h08);
    start_op(8'd9, 32'hFFFF_FFFF, 32'd2);   wait_done(1, k);
    lit("mul", k, 33, 32'hFFFF_FFFE, 32'h1, 8'h0E);
    start_op(8'd10, 32'd879199, 32'd250);   wait_done(0, k);
    lit("div", k, 33, 32'd3516, 32'd199, 8'h00);
    start_op(8'd10, 32'd879199, 32'd0);     wait_done(0, k);
    lit("div0", k, 1, 32'hFFFF_FFFF, 32'd879199, 8'h14);
    start_op(8'd8, 32'h8000_0010, 32'd4);   wait_done(0, k);
    lit("sar", k, 1, 32'hF800_0001, 32'h0, 8'h04);
    start_op(8'd37, 32'd123, 32'd456);      wait_done(0, k);
    lit("ill", k, 1, 32'h0, 32'h0, 8'h21);

    foreach (vecs[i]) begin
      model_op(vecs[i].op, vecs[i].x, vecs[i].y, r_m, h_m, f_m, lat_m);
      start_op(vecs[i].op, vecs[i].x, vecs[i].y);
      wait_done(0, k);
      chk($sformatf("vec%0d_lat", i), 64'(k), 64'(lat_m));
    end

    // Back-to-back: new start in the done cycle itself.
    start_op(8'd4, 32'h1234_5678, 32'hFFFF_FFFF); wait_done(0, k);
    alu_sel = 8'd3; a = 32'h0000_00F0; b = 32'h0000_000F; start = 1;
    @(negedge clk); start = 0;
    wait_done(0, k);
    lit("b2b_or", k, 1, 32'h0000_00FF, 32'h0, 8'h00);

    // Reset 10 cycles into a multiply: aborted, no done.
    start_op(8'd9, 32'd12345, 32'd678);
    repeat (9) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_ready", 64'(ready), 64'd1);
    chk("abort_outputs", {done, result, result_hi, flags}, 64'd0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (done) seen++; end
    chk("abort_no_done", 64'(seen), 64'd0);
    start_op(8'd0, 32'd2, 32'd3); wait_done(0, k);
    lit("add_after_rst", k, 1, 32'd5, 32'd0, 8'h00);

    // Reset and start on the same edge: start discarded.
    @(negedge clk);
    rst = 1; start = 1; alu_sel = 8'd0; a = 32'd7; b = 32'd8;
    @(negedge clk);
    rst = 0; start = 0;
    seen = 0;
    repeat (5) begin @(negedge clk); if (done) seen++; end
    chk("rst_start_no_done", 64'(seen), 64'd0);
    chk("rst_start_result", 64'(result), 64'd0);

    repeat (2) @(negedge clk);
    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
